// File: rtl/dial_counter.sv
// rtl/dial_counter.sv - circular dial rotation counter with land/pass tallies and valid/ready command handshake
// Optional DIAL_FAST_WRAP_EN: a STEP cycle with remaining >= DIAL_SIZE consumes a whole revolution in one edge.
module dial_counter #(
    parameter int STEP_W    = 10,
    parameter int COUNT_W   = 11,
    parameter int DIAL_SIZE = 100,
    parameter int POS_W     = 7,
    parameter int START_POS = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    output logic               ready,
    input  logic               step_direction,
    input  logic [STEP_W-1:0]  step_count,
    output logic [POS_W-1:0]   position,
    output logic [COUNT_W-1:0] land_count,
    output logic [COUNT_W-1:0] pass_count,
    output logic               done,
    output logic               overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(DIAL_SIZE - 1);
    localparam logic [POS_W-1:0]   POS_START = POS_W'(START_POS);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [STEP_W-1:0]  REV_STEPS = STEP_W'(DIAL_SIZE);

    logic [1:0]        state;
    logic              dir;
    logic [STEP_W-1:0] remaining;
    logic [POS_W-1:0]  pos_next;
    logic              do_wrap;

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    always_comb begin
        pos_next = position;
        if (dir) begin
            pos_next = (position == POS_LAST) ? '0 : position + 1'b1;
        end else begin
            pos_next = (position == '0) ? POS_LAST : position - 1'b1;
        end
    end

`ifdef DIAL_FAST_WRAP_EN
    // A full revolution leaves position unchanged and crosses 0 exactly once.
    assign do_wrap = (32'(remaining) >= 32'(DIAL_SIZE));
`else
    assign do_wrap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dir        <= 1'b0;
            remaining  <= '0;
            position   <= POS_START;
            land_count <= '0;
            pass_count <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        dir       <= step_direction;
                        remaining <= step_count;
                        state     <= (step_count != '0) ? S_STEP : S_DONE;
                    end
                end
                S_STEP: begin
                    if (do_wrap) begin
                        remaining <= remaining - REV_STEPS;
                        if (pass_count == COUNT_MAX) overflow <= 1'b1;
                        else                         pass_count <= pass_count + 1'b1;
                        if (remaining == REV_STEPS) state <= S_DONE;
                    end else begin
                        position  <= pos_next;
                        remaining <= remaining - 1'b1;
                        if (pos_next == '0) begin
                            if (pass_count == COUNT_MAX) overflow <= 1'b1;
                            else                         pass_count <= pass_count + 1'b1;
                        end
                        if (remaining == STEP_W'(1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (position == '0) begin
                        if (land_count == COUNT_MAX) overflow <= 1'b1;
                        else                         land_count <= land_count + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dial_counter.sv
// tb/tb_dial_counter.sv - randomized and directed bench for dial_counter against a closed-form dial model
module tb_dial_counter;

    localparam int STEP_W  = 10;
    localparam int BIG_W   = 11;
    localparam int SMALL_W = 2;
    localparam int D       = 100;
    localparam int POS_W   = 7;
    localparam int START   = 50;
`ifdef DIAL_FAST_WRAP_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid = 1'b0;
    logic              step_direction = 1'b0;
    logic [STEP_W-1:0] step_count = '0;

    logic               ready_a, done_a, ovf_a;
    logic [POS_W-1:0]   position_a;
    logic [BIG_W-1:0]   land_a, pass_a;
    logic               ready_b, done_b, ovf_b;
    logic [POS_W-1:0]   position_b;
    logic [SMALL_W-1:0] land_b, pass_b;

    dial_counter #(.STEP_W(STEP_W), .COUNT_W(BIG_W), .DIAL_SIZE(D), .POS_W(POS_W), .START_POS(START)) dut_a (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready_a), .step_direction(step_direction),
        .step_count(step_count), .position(position_a), .land_count(land_a), .pass_count(pass_a),
        .done(done_a), .overflow(ovf_a));

    dial_counter #(.STEP_W(STEP_W), .COUNT_W(SMALL_W), .DIAL_SIZE(D), .POS_W(POS_W), .START_POS(START)) dut_b (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready_b), .step_direction(step_direction),
        .step_count(step_count), .position(position_b), .land_count(land_b), .pass_count(pass_b),
        .done(done_b), .overflow(ovf_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    // Model: 0 idle, 1 rotating, 2 done; true (unsaturated) totals kept as ints.
    int m_state = 0, m_t = 0, m_L = 0, m_S = 0, m_p0 = START, m_pcur = START;
    bit m_dir = 1'b0;
    int m_pass = 0, m_land = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int latency(input int s);
        return FAST ? (s / D + s % D) : s;
    endfunction

    function automatic int wraps_at(input int t);
        if (!FAST) return 0;
        return (t < m_S / D) ? t : m_S / D;
    endfunction

    function automatic int clicks_at(input int t);
        if (!FAST) return t;
        return (t <= m_S / D) ? 0 : t - m_S / D;
    endfunction

    // Number of arrivals at 0 during c single clicks from p0.
    function automatic int crossings(input int p0, input bit dir, input int c);
        int d0;
        d0 = (p0 == 0) ? D : (dir ? D - p0 : p0);
        return (c >= d0) ? 1 + (c - d0) / D : 0;
    endfunction

    function automatic int pos_after(input int p0, input bit dir, input int c);
        return dir ? (p0 + c) % D : (((p0 - c) % D) + D) % D;
    endfunction

    function automatic int exp_pos();
        return (m_state == 0) ? m_pcur : pos_after(m_p0, m_dir, clicks_at(m_t));
    endfunction

    function automatic int exp_pass_true();
        if (m_state == 0) return m_pass;
        return m_pass + wraps_at(m_t) + crossings(m_p0, m_dir, clicks_at(m_t));
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_t = 0; m_pcur = START; m_pass = 0; m_land = 0;
        end else if (m_state == 0) begin
            if (valid) begin
                m_p0 = m_pcur; m_dir = step_direction; m_S = int'(step_count);
                m_t = 0; m_L = latency(m_S);
                m_state = (m_L == 0) ? 2 : 1;
            end
        end else if (m_state == 1) begin
            m_t++;
            if (m_t == m_L) m_state = 2;
        end else begin
            m_pass = exp_pass_true();
            m_pcur = exp_pos();
            if (m_pcur == 0) m_land++;
            m_state = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            int pt;
            pt = exp_pass_true();
            check("position_a", int'(position_a), exp_pos());
            check("pass_a", int'(pass_a), sat(pt, BIG_W));
            check("land_a", int'(land_a), sat(m_land, BIG_W));
            check("ready_a", int'(ready_a), int'(m_state == 0));
            check("done_a", int'(done_a), int'(m_state == 2));
            check("overflow_a", int'(ovf_a), int'(pt > (1 << BIG_W) - 1 || m_land > (1 << BIG_W) - 1));
            check("position_b", int'(position_b), exp_pos());
            check("pass_b", int'(pass_b), sat(pt, SMALL_W));
            check("land_b", int'(land_b), sat(m_land, SMALL_W));
            check("ready_b", int'(ready_b), int'(m_state == 0));
            check("done_b", int'(done_b), int'(m_state == 2));
            check("overflow_b", int'(ovf_b), int'(pt > (1 << SMALL_W) - 1 || m_land > (1 << SMALL_W) - 1));
        end
    end

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_cmd(input bit dir, input int s, output int lat);
        int guard;
        valid = 1'b1; step_direction = dir; step_count = STEP_W'(s);
        guard = 0;
        while (!ready_a && guard < 5000) begin tick(); guard++; end
        tick();
        valid = 1'b0;
        step_count = STEP_W'($urandom);
        step_direction = 1'(~dir);
        lat = 0;
        while (!done_a && lat < 5000) begin tick(); lat++; end
        check("done_timeout", int'(lat < 5000), 1);
        tick();
    endtask

    function automatic int pick_steps();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 3) return int'($urandom_range(0, 3));
        if (r < 7) return int'($urandom_range(0, 150));
        if (r < 8) return int'($urandom_range(0, 1023));
        return -1;
    endfunction

    initial begin
        int lat;
        int s;
        do_reset();
        armed = 1'b1;
        repeat (3) tick();
        check("reset_position", int'(position_a), 50);
        check("reset_land", int'(land_a), 0);
        check("reset_pass", int'(pass_a), 0);
        check("reset_ready", int'(ready_a), 1);
        check("reset_done", int'(done_a), 0);
        check("reset_overflow", int'(ovf_a), 0);

        run_cmd(1'b1, 50, lat);
        check("r50_latency", lat, 50);
        check("r50_position", int'(position_a), 0);
        check("r50_land", int'(land_a), 1);
        check("r50_pass", int'(pass_a), 1);
        check("r50_ready", int'(ready_a), 1);

        do_reset();
        run_cmd(1'b0, 68, lat);
        check("l68_position", int'(position_a), 82);
        run_cmd(1'b0, 30, lat);
        check("l30_position", int'(position_a), 52);
        run_cmd(1'b1, 48, lat);
        check("r48_position", int'(position_a), 0);
        check("seq_pass", int'(pass_a), 2);
        check("seq_land", int'(land_a), 1);

        do_reset();
        run_cmd(1'b1, 1000, lat);
        check("r1000_latency", lat, FAST ? 10 : 1000);
        check("r1000_position", int'(position_a), 50);
        check("r1000_pass", int'(pass_a), 10);
        check("r1000_land", int'(land_a), 0);

        // Valid held high through a busy period; step_count change while busy must be ignored.
        do_reset();
        valid = 1'b1; step_direction = 1'b1; step_count = STEP_W'(50);
        tick();
        step_count = '0;
        lat = 0;
        while (!done_a && lat < 5000) begin tick(); lat++; end
        check("hold_first_latency", lat, 50);
        tick();
        check("hold_land_first", int'(land_a), 1);
        check("hold_ready_idle", int'(ready_a), 1);
        tick();
        valid = 1'b0;
        check("zero_done", int'(done_a), 1);
        check("zero_busy", int'(ready_a), 0);
        tick();
        check("zero_ready", int'(ready_a), 1);
        check("zero_land", int'(land_a), 2);
        check("zero_pass", int'(pass_a), 1);
        check("zero_position", int'(position_a), 0);

        do_reset();
        repeat (5) run_cmd(1'b1, 100, lat);
        check("sat_pass_b", int'(pass_b), 3);
        check("sat_ovf_b", int'(ovf_b), 1);
        check("sat_pass_a", int'(pass_a), 5);
        check("sat_ovf_a", int'(ovf_a), 0);
        valid = 1'b1; step_direction = 1'b1; step_count = STEP_W'(100);
        tick();
        valid = 1'b0;
        repeat (FAST ? 0 : 20) tick();
        check("mid_step_busy", int'(ready_b), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_position_b", int'(position_b), 50);
        check("rst_pass_b", int'(pass_b), 0);
        check("rst_land_b", int'(land_b), 0);
        check("rst_ovf_b", int'(ovf_b), 0);
        check("rst_ready_b", int'(ready_b), 1);
        check("rst_done_b", int'(done_b), 0);

        for (int i = 0; i < 30000; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            step_direction = 1'($urandom);
            s = pick_steps();
            if (s < 0) s = step_direction ? (D - m_pcur) % D : m_pcur;
            step_count = STEP_W'(s);
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0;
        valid = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
